// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Bundle of the serial line and the receive-side byte handshake
//               of the 8N1 UART receiver.
//               master : receiver side. It samples the line and the read
//                        strobe, and drives the byte, valid and error flags.
//               slave  : consumer side. It drives the line and the read
//                        strobe, and observes the byte and the flags.
// Signals     : uart_rx_i    serial input, idle high, asynchronous to clk
//               uart_rd_i    1-cycle read acknowledge from the consumer
//               uart_dat_o   received byte
//               uart_valid_o unread byte present on uart_dat_o
//               uart_ferr_o  stop bit of the byte on uart_dat_o was 0
//               uart_ovr_o   sticky, a byte was dropped since the last read
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  logic       uart_rx_i;
  logic       uart_rd_i;
  logic [7:0] uart_dat_o;
  logic       uart_valid_o;
  logic       uart_ferr_o;
  logic       uart_ovr_o;

  modport master (
    input  uart_rx_i,
    input  uart_rd_i,
    output uart_dat_o,
    output uart_valid_o,
    output uart_ferr_o,
    output uart_ovr_o
  );

  modport slave (
    output uart_rx_i,
    output uart_rd_i,
    input  uart_dat_o,
    input  uart_valid_o,
    input  uart_ferr_o,
    input  uart_ovr_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Oversamples the serial line 16x per bit,
//               de-serialises LSB-first bytes and presents each byte on a
//               valid/read handshake, with framing-error and overrun flags.
// Parameters  : CLK_HZ  system clock frequency in Hz
//               BAUD    line bit rate
//               (DIV = CLK_HZ/(BAUD*16) clocks per oversample tick, >= 1)
// Ports       : sys_clk_i   system clock, rising edge
//               sys_rstn_i  synchronous active-low reset
//               bus         uart_rx_if.master (line in, rd in, byte/flags out)
// Option      : UART_RX_MAJORITY_EN - when defined, every bit is sampled on
//               ticks 7, 8 and 9 and a 2-of-3 vote decides at tick 9.
//               When undefined, a single sample on tick 8 is used.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic      sys_clk_i,
  input  logic      sys_rstn_i,
  uart_rx_if.master bus
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Line synchroniser and edge history
  logic          rx_meta;
  logic          rxs;
  logic          rxs_d;
  // warm[1] says rxs now carries a real line sample rather than reset value
  logic [1:0]    warm;
  // armed once the line has really been seen high; a line held low out of
  // reset never produces a start edge
  logic          armed;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [3:0]    sub;       // ticks already elapsed in the current bit
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    dat;
  logic          valid;
  logic          ferr;
  logic          ovr;

  logic          tick;
  logic          fall;
  logic          sample_now;
  logic          sample_val;

`ifdef UART_RX_MAJORITY_EN
  logic          s7;
  logic          s8;
`endif

  assign tick = (tcnt == TICK_LAST);
  assign fall = armed && rxs_d && !rxs;

  // sub == k-1 on the k-th tick of a bit
`ifdef UART_RX_MAJORITY_EN
  assign sample_now = tick && (sub == 4'd8);
  assign sample_val = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`else
  assign sample_now = tick && (sub == 4'd7);
  assign sample_val = rxs;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      warm    <= 2'b00;
      armed   <= 1'b0;
      state   <= IDLE;
      tcnt    <= '0;
      sub     <= 4'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      dat     <= 8'h00;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s7      <= 1'b1;
      s8      <= 1'b1;
`endif
    end else begin
      rx_meta <= bus.uart_rx_i;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      warm    <= {warm[0], 1'b1};
      if (warm[1] && rxs) begin
        armed <= 1'b1;
      end

      // Consumer read; a delivery later in this block may re-assert valid
      if (bus.uart_rd_i && valid) begin
        valid <= 1'b0;
        ovr   <= 1'b0;
      end

`ifdef UART_RX_MAJORITY_EN
      if (state != IDLE && tick && sub == 4'd6) begin
        s7 <= rxs;
      end
      if (state != IDLE && tick && sub == 4'd7) begin
        s8 <= rxs;
      end
`endif

      case (state)
        IDLE: begin
          tcnt <= '0;
          sub  <= 4'd0;
          if (fall) begin
            state <= START;
          end
        end

        default: begin
          // Tick generator and per-bit tick count; sub wraps after 16 ticks
          if (tick) begin
            tcnt <= '0;
            sub  <= sub + 4'd1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end

          if (sample_now) begin
            case (state)
              START: begin
                if (sample_val) begin
                  state <= IDLE;          // false start
                end else begin
                  state   <= DATA;
                  bit_idx <= 3'd0;
                end
              end
              DATA: begin
                shreg[bit_idx] <= sample_val;
                if (bit_idx == 3'd7) begin
                  state <= STOP;
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                end
              end
              STOP: begin
                // Returning to IDLE at mid-stop lets the next start edge in
                // within half a bit.
                state <= IDLE;
                if (!valid || bus.uart_rd_i) begin
                  dat   <= shreg;
                  ferr  <= ~sample_val;
                  valid <= 1'b1;
                end else begin
                  ovr <= 1'b1;
                end
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.uart_dat_o   = dat;
  assign bus.uart_valid_o = valid;
  assign bus.uart_ferr_o  = ferr;
  assign bus.uart_ovr_o   = ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at CLK_HZ=3200, BAUD=100
//               (DIV=2, one bit = 32 clocks). Expected bytes are queued as
//               frames are driven and popped when valid rises.
// Option      : UART_RX_MAJORITY_EN selects the majority-vote expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_HZ   = 3200;
  localparam int BAUD     = 100;
  localparam int BIT_CLKS = 32;
`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT        = 309;  // start drive to delivery edge
  localparam logic [7:0] GLITCH_DAT = 8'h00;
`else
  localparam int         LAT        = 307;
  localparam logic [7:0] GLITCH_DAT = 8'h01;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  uart_rx_if u_if ();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rstn),
    .bus        (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dat;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_dat;
    logic       exp_ferr;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  int   total      = 0;
  int   bad        = 0;
  int   cyc_cnt    = 0;
  int   start_cyc  = 0;
  int   rise_cyc   = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Monitor: every new byte must match the head of the scoreboard
  always @(negedge clk) begin
    if (u_if.uart_valid_o && !prev_valid) begin
      rise_cyc = cyc_cnt;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %02h want none", u_if.uart_dat_o);
      end else begin
        mon_e = sb.pop_front();
        check("rx_dat", {24'd0, u_if.uart_dat_o}, {24'd0, mon_e.dat});
        check("rx_ferr", {31'd0, u_if.uart_ferr_o}, {31'd0, mon_e.ferr});
      end
    end
    prev_valid = u_if.uart_valid_o;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic fe);
    exp_t e;
    e.dat  = d;
    e.ferr = fe;
    sb.push_back(e);
  endtask

  // Leaves the line at the stop-bit level when it returns
  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc_cnt;
    u_if.uart_rx_i = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      u_if.uart_rx_i = d[i];
      cyc(BIT_CLKS);
    end
    u_if.uart_rx_i = stop;
    cyc(BIT_CLKS);
  endtask

  task automatic read_byte();
    u_if.uart_rd_i = 1'b1;
    cyc(1);
    u_if.uart_rd_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[1] = '{8'hC3, 1'b1, 8'hC3, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};

    // Reset and idle
    u_if.uart_rx_i = 1'b1;
    u_if.uart_rd_i = 1'b0;
    rstn = 1'b0;
    cyc(3);
    check("rst_dat", {24'd0, u_if.uart_dat_o}, 32'h00);
    check("rst_valid", {31'd0, u_if.uart_valid_o}, 32'd0);
    check("rst_ferr", {31'd0, u_if.uart_ferr_o}, 32'd0);
    check("rst_ovr", {31'd0, u_if.uart_ovr_o}, 32'd0);
    rstn = 1'b1;
    cyc(1000);
    check("idle_valid", {31'd0, u_if.uart_valid_o}, 32'd0);

    // First byte and its latency
    expect_byte(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    cyc(16);
    check("a5_popped", sb.size(), 32'd0);
    check("a5_latency", rise_cyc - start_cyc, LAT);
    read_byte();
    check("a5_read_clr", {31'd0, u_if.uart_valid_o}, 32'd0);

    // Short low glitch is a false start
    u_if.uart_rx_i = 1'b0;
    cyc(8);
    u_if.uart_rx_i = 1'b1;
    cyc(64);
    check("glitch_valid", {31'd0, u_if.uart_valid_o}, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      expect_byte(vecs[i].exp_dat, vecs[i].exp_ferr);
      send_frame(vecs[i].d, vecs[i].stop);
      u_if.uart_rx_i = 1'b1;
      cyc(16);
      check("vec_popped", sb.size(), 32'd0);
      check("vec_valid", {31'd0, u_if.uart_valid_o}, 32'd1);
      read_byte();
      check("vec_read_clr", {31'd0, u_if.uart_valid_o}, 32'd0);
    end

    // Framing error followed by a break
    expect_byte(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b0);
    cyc(5 * BIT_CLKS);
    check("brk_popped", sb.size(), 32'd0);
    check("brk_ferr", {31'd0, u_if.uart_ferr_o}, 32'd1);
    u_if.uart_rx_i = 1'b1;
    cyc(BIT_CLKS);
    check("brk_no_ovr", {31'd0, u_if.uart_ovr_o}, 32'd0);
    read_byte();
    expect_byte(8'h01, 1'b0);
    send_frame(8'h01, 1'b1);
    cyc(16);
    check("post_brk_popped", sb.size(), 32'd0);
    check("post_brk_dat", {24'd0, u_if.uart_dat_o}, 32'h01);
    check("post_brk_ferr", {31'd0, u_if.uart_ferr_o}, 32'd0);
    read_byte();

    // Overrun: second byte dropped
    expect_byte(8'h11, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    cyc(16);
    check("ovr_dat", {24'd0, u_if.uart_dat_o}, 32'h11);
    check("ovr_flag", {31'd0, u_if.uart_ovr_o}, 32'd1);
    check("ovr_valid", {31'd0, u_if.uart_valid_o}, 32'd1);
    read_byte();
    check("ovr_rd_valid", {31'd0, u_if.uart_valid_o}, 32'd0);
    check("ovr_rd_flag", {31'd0, u_if.uart_ovr_o}, 32'd0);

    // Read in the same cycle as the second delivery
    expect_byte(8'h11, 1'b0);
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        cyc(10 * BIT_CLKS + LAT - 1);
        u_if.uart_rd_i = 1'b1;
        cyc(1);
        u_if.uart_rd_i = 1'b0;
      end
    join
    cyc(16);
    check("rdsame_popped", sb.size(), 32'd0);
    check("rdsame_dat", {24'd0, u_if.uart_dat_o}, 32'h22);
    check("rdsame_valid", {31'd0, u_if.uart_valid_o}, 32'd1);
    check("rdsame_ovr", {31'd0, u_if.uart_ovr_o}, 32'd0);
    read_byte();

    // 0x00 with a 2-clock high pulse over the mid-point of data bit 0
    expect_byte(GLITCH_DAT, 1'b0);
    u_if.uart_rx_i = 1'b0;
    cyc(BIT_CLKS);
    cyc(15);
    u_if.uart_rx_i = 1'b1;
    cyc(2);
    u_if.uart_rx_i = 1'b0;
    cyc(15);
    cyc(7 * BIT_CLKS);
    u_if.uart_rx_i = 1'b1;
    cyc(BIT_CLKS);
    cyc(16);
    check("vote_popped", sb.size(), 32'd0);
    check("vote_dat", {24'd0, u_if.uart_dat_o}, {24'd0, GLITCH_DAT});

    // Reset in the middle of a 0xFF frame, with the previous byte unread
    u_if.uart_rx_i = 1'b0;
    cyc(BIT_CLKS);
    u_if.uart_rx_i = 1'b1;
    cyc(80);
    rstn = 1'b0;
    cyc(3);
    check("mid_rst_dat", {24'd0, u_if.uart_dat_o}, 32'h00);
    check("mid_rst_valid", {31'd0, u_if.uart_valid_o}, 32'd0);
    check("mid_rst_ferr", {31'd0, u_if.uart_ferr_o}, 32'd0);
    check("mid_rst_ovr", {31'd0, u_if.uart_ovr_o}, 32'd0);
    rstn = 1'b1;
    cyc(64);
    expect_byte(8'h42, 1'b0);
    send_frame(8'h42, 1'b1);
    cyc(16);
    check("after_rst_popped", sb.size(), 32'd0);
    check("after_rst_dat", {24'd0, u_if.uart_dat_o}, 32'h42);
    read_byte();
    cyc(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
